// File: rtl/ntsc_sync_gen.sv
// ntsc_sync_gen: NTSC raster/subcarrier timing for the S2 encoder; define NTSC_SYNC_INTERLACE_EN for 262/263-line interlace
module ntsc_sync_gen #(
  parameter int H_TOTAL      = 910,
  parameter int H_SYNC       = 67,
  parameter int H_DISP_START = 160,
  parameter int H_DISP_LEN   = 640,
  parameter int V_TOTAL      = 262,
  parameter int V_SYNC       = 3,
  parameter int V_DISP_START = 40,
  parameter int V_DISP_LEN   = 200,
  parameter int PIX_DIV      = 2
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_EN,
  output logic [1:0] O_SC,
  output logic       O_ICLK_EN,
  output logic       O_HSYNC,
  output logic       O_VSYNC,
  output logic       O_DISP,
  output logic       O_FSTART,
  output logic [9:0] O_HCNT,
  output logic [8:0] O_VCNT,
  output logic       O_FIELD
);
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  logic [9:0]    hcnt;
  logic [8:0]    vcnt;
  logic [1:0]    sc;
  logic [PW-1:0] pcnt;
  logic          field;
  logic [31:0]   h, v;
  logic          h_last, v_last, vs;
  assign h      = 32'(hcnt);
  assign v      = 32'(vcnt);
  assign h_last = h == 32'(H_TOTAL - 1);
`ifdef NTSC_SYNC_INTERLACE_EN
  assign v_last = v == 32'(V_TOTAL - 1) + 32'(field);
  assign vs     = field ? ((v == 32'd0 && h >= 32'(H_TOTAL / 2)) || (v != 32'd0 && v < 32'(V_SYNC)) ||
                           (v == 32'(V_SYNC) && h < 32'(H_TOTAL / 2)))
                        : v < 32'(V_SYNC);
  // field flips together with the vcnt wrap so the next field starts with its own line total
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) field <= 1'b0;
    else if (I_EN && h_last && v_last) field <= ~field;
`else
  assign v_last = v == 32'(V_TOTAL - 1);
  assign vs     = v < 32'(V_SYNC);
  assign field  = 1'b0;
`endif
  assign O_SC    = sc;
  assign O_HCNT  = hcnt;
  assign O_VCNT  = vcnt;
  assign O_FIELD = field;
  // subcarrier phase runs freely so colour phase never depends on the raster enable
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) sc <= '0;
    else sc <= sc + 2'd1;
  // raster and pixel counters advance only while enabled; pixel phase restarts each line
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      hcnt <= '0;
      vcnt <= '0;
      pcnt <= '0;
    end else if (I_EN) begin
      hcnt <= h_last ? '0 : hcnt + 10'd1;
      if (h_last) vcnt <= v_last ? '0 : vcnt + 9'd1;
      pcnt <= (pcnt == PW'(PIX_DIV - 1) || h_last) ? '0 : pcnt + PW'(1);
    end
  // registered decodes of the pre-edge counts, one clock behind O_HCNT/O_VCNT
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      O_HSYNC   <= 1'b0;
      O_VSYNC   <= 1'b0;
      O_DISP    <= 1'b0;
      O_ICLK_EN <= 1'b0;
      O_FSTART  <= 1'b0;
    end else begin
      O_HSYNC   <= h < 32'(H_SYNC);
      O_VSYNC   <= vs;
      O_DISP    <= h >= 32'(H_DISP_START) && h < 32'(H_DISP_START + H_DISP_LEN) &&
                   v >= 32'(V_DISP_START) && v < 32'(V_DISP_START + V_DISP_LEN);
      O_ICLK_EN <= I_EN && pcnt == PW'(PIX_DIV - 1);
      O_FSTART  <= I_EN && hcnt == 10'd0 && vcnt == 9'd0;
    end
endmodule
